// File: rtl/led_scan_ctrl.sv
// 8-LED scanner: prescaled step ticks drive a 3-LED window in bounce, wrap or blink mode.
// Defining LEDSCAN_SWEEP_CNT_EN adds the saturating sweeps[7:0] event counter output.
module led_scan_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [3:0]       dwell,
  output logic [WIDTH-1:0] leds,
  output logic             dir,
  output logic             tick,
  output logic             at_end
`ifdef LEDSCAN_SWEEP_CNT_EN
  ,
  output logic [7:0]       sweeps
`endif
);

  localparam int POS_W = (WIDTH - 2 > 1) ? $clog2(WIDTH - 2) : 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 3);
  localparam logic [WIDTH-1:0] WIN     = WIDTH'(7);

  localparam logic [1:0] M_BOUNCE = 2'd0;
  localparam logic [1:0] M_WRAPL  = 2'd1;
  localparam logic [1:0] M_WRAPR  = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] cnt_reg, cnt_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic             dir_reg, dir_next;
  logic             phase_reg, phase_next;
  logic [3:0]       dwell_cnt_reg, dwell_cnt_next;
  logic [WIDTH-1:0] leds_reg, leds_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pos_reg       <= '0;
      dir_reg       <= 1'b0;
      phase_reg     <= 1'b1;
      dwell_cnt_reg <= '0;
      leds_reg      <= WIN;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pos_reg       <= pos_next;
      dir_reg       <= dir_next;
      phase_reg     <= phase_next;
      dwell_cnt_reg <= dwell_cnt_next;
      leds_reg      <= leds_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    pos_next       = pos_reg;
    dir_next       = dir_reg;
    phase_next     = phase_reg;
    dwell_cnt_next = dwell_cnt_reg;
    if (!en) begin
      state_next     = IDLE;
      cnt_next       = '0;
      dwell_cnt_next = '0;
    end else begin
      cnt_next = tick ? '0 : cnt_reg + 1'b1;
      if (state_reg == IDLE)
        state_next = RUN;
      // Any non-bounce mode abandons the endpoint hold straight away.
      if (state_reg == DWELL && mode != M_BOUNCE) begin
        state_next     = RUN;
        dwell_cnt_next = '0;
      end
      if (tick) begin
        if (state_reg == DWELL && mode == M_BOUNCE) begin
          if (dwell_cnt_reg == dwell) begin
            dwell_cnt_next = '0;
            state_next     = RUN;
            dir_next       = ~dir_reg;
            pos_next       = dir_reg ? pos_reg + 1'b1 : pos_reg - 1'b1;
          end else begin
            dwell_cnt_next = dwell_cnt_reg + 1'b1;
          end
        end else begin
          phase_next = 1'b1;
          case (mode)
            M_BOUNCE: begin
              if (!dir_reg) begin
                if (pos_reg == POS_MAX) begin
                  dir_next = 1'b1;
                  pos_next = pos_reg - 1'b1;
                end else begin
                  pos_next = pos_reg + 1'b1;
                  if (pos_next == POS_MAX && dwell != 4'd0)
                    state_next = DWELL;
                end
              end else begin
                if (pos_reg == '0) begin
                  dir_next = 1'b0;
                  pos_next = pos_reg + 1'b1;
                end else begin
                  pos_next = pos_reg - 1'b1;
                  if (pos_next == '0 && dwell != 4'd0)
                    state_next = DWELL;
                end
              end
            end
            M_WRAPL: begin
              dir_next = 1'b0;
              pos_next = (pos_reg == POS_MAX) ? '0 : pos_reg + 1'b1;
            end
            M_WRAPR: begin
              dir_next = 1'b1;
              pos_next = (pos_reg == '0) ? POS_MAX : pos_reg - 1'b1;
            end
            default: phase_next = ~phase_reg;
          endcase
        end
      end
    end
    leds_next = phase_next ? (WIN << pos_next) : '0;
  end

  always_comb begin
    tick   = en && (cnt_reg == div);
    at_end = (pos_reg == '0) || (pos_reg == POS_MAX);
    leds   = leds_reg;
    dir    = dir_reg;
  end

`ifdef LEDSCAN_SWEEP_CNT_EN
  logic [7:0] sweeps_reg;
  logic       sweep_evt;

  // In bounce mode dir only ever flips at a reversal, so a flip marks one.
  always_comb begin
    sweep_evt = tick && (
                  (mode == M_BOUNCE && dir_next != dir_reg) ||
                  (mode == M_WRAPL  && pos_reg == POS_MAX) ||
                  (mode == M_WRAPR  && pos_reg == '0) ||
                  (mode == M_BLINK  && !phase_reg));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sweeps_reg <= '0;
    else if (sweep_evt && sweeps_reg != 8'hFF)
      sweeps_reg <= sweeps_reg + 1'b1;
  end

  assign sweeps = sweeps_reg;
`endif

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Directed bench for led_scan_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_led_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [3:0]  dwell;
  logic [7:0]  leds;
  logic        dir, tick, at_end;
`ifdef LEDSCAN_SWEEP_CNT_EN
  logic [7:0]  sweeps;
`endif
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  led_scan_ctrl #(.WIDTH(8), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .div(div), .dwell(dwell),
    .leds(leds), .dir(dir), .tick(tick), .at_end(at_end)
`ifdef LEDSCAN_SWEEP_CNT_EN
    , .sweeps(sweeps)
`endif
  );

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; div = 16'd0; dwell = 4'd0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (leds !== 8'h07) begin err_cnt++; $display("FAIL reset_leds: got %h expected 07", leds); end
    vec_cnt++; if (dir !== 1'b0) begin err_cnt++; $display("FAIL reset_dir: got %b expected 0", dir); end
    vec_cnt++; if (tick !== 1'b0) begin err_cnt++; $display("FAIL reset_tick: got %b expected 0", tick); end
    vec_cnt++; if (at_end !== 1'b1) begin err_cnt++; $display("FAIL reset_at_end: got %b expected 1", at_end); end
`ifdef LEDSCAN_SWEEP_CNT_EN
    vec_cnt++; if (sweeps !== 8'd0) begin err_cnt++; $display("FAIL reset_sweeps: got %0d expected 0", sweeps); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++; if (leds !== 8'h07) begin err_cnt++; $display("FAIL idle_hold: got %h expected 07", leds); end
    $display("reset: leds=%h dir=%b at_end=%b", leds, dir, at_end);
  endtask

  task automatic test_bounce();
    logic [7:0] exp_l [11] = '{8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E};
    logic       exp_d [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    en = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (leds !== exp_l[i] || dir !== exp_d[i] || tick !== 1'b1) begin
        err_cnt++;
        $display("FAIL bounce[%0d]: got leds=%h dir=%b tick=%b expected leds=%h dir=%b tick=1",
                 i, leds, dir, tick, exp_l[i], exp_d[i]);
      end
    end
    $display("bounce: 11 steps, final leds=%h dir=%b", leds, dir);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_dwell();
    int ticks = 0;
    int waited = 0;
    en = 1'b1; div = 16'd3; dwell = 4'd2; mode = 2'd0;
    while (leds !== 8'hE0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    vec_cnt++; if (waited != 16) begin err_cnt++; $display("FAIL dwell_arrive: got %0d cycles expected 16", waited); end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (tick === 1'b1) ticks++;
      vec_cnt++;
      if (leds !== 8'hE0 || at_end !== 1'b1) begin
        err_cnt++;
        $display("FAIL dwell_hold[%0d]: got leds=%h at_end=%b expected leds=E0 at_end=1", i, leds, at_end);
      end
    end
    vec_cnt++; if (ticks != 3) begin err_cnt++; $display("FAIL dwell_ticks: got %0d expected 3", ticks); end
    @(negedge clk);
    vec_cnt++;
    if (leds !== 8'h70 || dir !== 1'b1) begin
      err_cnt++; $display("FAIL dwell_leave: got leds=%h dir=%b expected leds=70 dir=1", leds, dir);
    end
    $display("dwell: held E0 12 cycles with %0d ticks, then leds=%h", ticks, leds);
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_l [8] = '{8'hE0, 8'h07, 8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07};
    logic       exp_d [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    en = 1'b1; mode = 2'd1; div = 16'd0; dwell = 4'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) mode = 2'd2;
      vec_cnt++;
      if (leds !== exp_l[i] || dir !== exp_d[i]) begin
        err_cnt++;
        $display("FAIL wrap[%0d]: got leds=%h dir=%b expected leds=%h dir=%b", i, leds, dir, exp_l[i], exp_d[i]);
      end
    end
    vec_cnt++; if (at_end !== 1'b1) begin err_cnt++; $display("FAIL wrap_at_end: got %b expected 1", at_end); end
    $display("wrap: left E0->07, right 07->E0, final leds=%h", leds);
  endtask

  task automatic test_blink();
    logic [7:0] exp_l [8] = '{8'h07, 8'h00, 8'h00, 8'h07, 8'h07, 8'h00, 8'h00, 8'h0E};
    mode = 2'd3; div = 16'd1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 5) mode = 2'd0;
      vec_cnt++;
      if (leds !== exp_l[i]) begin
        err_cnt++; $display("FAIL blink[%0d]: got leds=%h expected %h", i, leds, exp_l[i]);
      end
    end
    $display("blink: toggled at div=1, bounce resumed with leds=%h", leds);
  endtask

  task automatic test_enable();
    div = 16'd0;
    @(negedge clk);
    vec_cnt++; if (leds !== 8'h1C) begin err_cnt++; $display("FAIL en_setup: got %h expected 1C", leds); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (leds !== 8'h1C || tick !== 1'b0 || at_end !== 1'b0) begin
        err_cnt++;
        $display("FAIL en_freeze[%0d]: got leds=%h tick=%b at_end=%b expected leds=1C tick=0 at_end=0", i, leds, tick, at_end);
      end
    end
    en = 1'b1; div = 16'd2;
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (leds !== 8'h1C || tick !== 1'b1) begin
      err_cnt++; $display("FAIL en_resume_wait: got leds=%h tick=%b expected leds=1C tick=1", leds, tick);
    end
    @(negedge clk);
    vec_cnt++; if (leds !== 8'h38) begin err_cnt++; $display("FAIL en_resume_step: got %h expected 38", leds); end
    $display("enable: frozen 10 cycles, first step 3 cycles after resume, leds=%h", leds);
  endtask

  task automatic test_midreset();
    logic [7:0] exp_l [3] = '{8'h70, 8'hE0, 8'h70};
    div = 16'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (leds !== exp_l[i]) begin err_cnt++; $display("FAIL mid_setup[%0d]: got %h expected %h", i, leds, exp_l[i]); end
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if (leds !== 8'h07 || dir !== 1'b0 || at_end !== 1'b1) begin
      err_cnt++; $display("FAIL mid_reset: got leds=%h dir=%b at_end=%b expected leds=07 dir=0 at_end=1", leds, dir, at_end);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    @(negedge clk);
    $display("midreset: async reset returned leds=%h dir=%b", leds, dir);
  endtask

`ifdef LEDSCAN_SWEEP_CNT_EN
  task automatic test_sweeps();
    en = 1'b1; mode = 2'd0; div = 16'd0; dwell = 4'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 14) begin
        vec_cnt++; if (sweeps !== 8'd2) begin err_cnt++; $display("FAIL sweeps_two: got %0d expected 2", sweeps); end
      end
    end
    vec_cnt++; if (sweeps !== 8'd3) begin err_cnt++; $display("FAIL sweeps_three: got %0d expected 3", sweeps); end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++; if (sweeps !== 8'd0) begin err_cnt++; $display("FAIL sweeps_reset: got %0d expected 0", sweeps); end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    $display("sweeps: counted 3 reversals, cleared by reset");
  endtask
`endif

  initial begin
    test_reset();
    test_bounce();
    test_dwell();
    test_wrap();
    test_blink();
    test_enable();
    test_midreset();
`ifdef LEDSCAN_SWEEP_CNT_EN
    test_sweeps();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/led_scan_ctrl.md
Name: led_scan_ctrl

Overview:
- Sequencing controller for the 8-LED scanner used on the lab boards.
- Divides the board clock into step ticks and moves a 3-LED window across the LED bank.
- Scan modes: bounce (classic back-and-forth sweep), wrap-left, wrap-right and blink, with a programmable dwell at the bounce endpoints.
- Sits between the top-level switch/button inputs and the LED pins.

Parameters:
- WIDTH, 8, number of LEDs; must be at least 4.
- DIV_W, 16, width of the step-period divider value.

Ports:
- clk  input  1  system clock; all state is updated on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; when low, the pattern freezes.
- mode  input  2  scan mode: 0 bounce, 1 wrap-left, 2 wrap-right, 3 blink.
- div  input  DIV_W  step period minus 1, in clk cycles.
- dwell  input  4  extra ticks to hold at a bounce endpoint.
- leds  output  WIDTH  LED drive, registered.
- dir  output  1  current direction: 0 = toward MSB, 1 = toward LSB.
- tick  output  1  one-cycle step strobe.
- at_end  output  1  high while the window sits at either extreme.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pos=0, dir=0, leds=0x07 (window at LSB), prescaler=0, dwell_cnt=0, tick=0, at_end=1, blink phase=on, state=IDLE.
- Window definition: leds = 3'b111 << pos, with pos in 0..WIDTH-3. In blink-off phase, leds = 0.
- Prescaler:
  - While en=1, cnt increments each cycle.
  - When cnt==div, tick=1 for that cycle and cnt returns to 0.
  - div=0 gives a tick every cycle.
  - en=0 clears cnt and forces tick=0.
  - A change of div mid-count takes effect on the compare immediately. If cnt>div, the counter wraps naturally through its maximum value; this is accepted.
- States:
  - IDLE: en=0; leds, pos and dir held. Goes to RUN when en=1.
  - RUN: each tick performs one step for the current mode. Goes to DWELL on arrival at an endpoint in bounce mode when dwell!=0.
  - DWELL: each tick increments dwell_cnt. When dwell_cnt==dwell, the next tick reverses dir, steps, clears dwell_cnt and returns to RUN.
  - en=0 from any state goes to IDLE and clears dwell_cnt.
- Step rules (evaluated on a tick; mode is sampled on that tick):
  - Bounce:
    - dir=0 and pos<WIDTH-3: pos+1.
    - dir=0 and pos==WIDTH-3: set dir=1 and pos-1 (when dwell==0).
    - dir=1 mirrors this at pos==0.
    - With dwell=0, the sequence is 07,0E,1C,38,70,E0,70,38,...
  - Wrap-left: pos+1; pos==WIDTH-3 goes to 0. dir forced to 0.
  - Wrap-right: pos-1; pos==0 goes to WIDTH-3. dir forced to 1.
  - Blink: pos unchanged; phase toggles on each tick.
- Mode switching:
  - Leaving blink restores phase=on on the same tick as the first step of the new mode.
  - Entering a wrap mode from DWELL returns to RUN at once and applies the wrap step.
- at_end: combinational from pos; 1 when pos==0 or pos==WIDTH-3, in all modes.
- Simultaneous events: if en falls on a tick cycle, no step occurs; en has priority.
- Reset mid-sweep: immediate return to the reset values, with no glitch-free guarantee on leds during assertion.

Optional Feature:
- Macro: LEDSCAN_SWEEP_CNT_EN.
- Defined: adds output sweeps[7:0], reset 0. It increments once per bounce reversal, wrap-around or blink off-to-on transition, and saturates at 255. It is cleared only by reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset then en=1, mode=0, div=0, dwell=0 -> leds on successive cycles: 07,0E,1C,38,70,E0,70,38,1C,0E,07,0E. dir toggles when leaving E0 and when leaving 07.
- mode=0, div=3, dwell=2 -> tick every 4th cycle. leds holds E0 for 3 ticks (12 cycles) with at_end=1, then goes to 70.
- mode=1, div=0 starting at pos 5 (E0) -> next leds 07. mode=2 from 07 -> E0.
- mode=3, div=1 -> leds alternates 07/00 every 2 cycles. Switching to mode=0 -> next tick leds=0E.
- en dropped at leds=1C for 10 cycles -> leds stays 1C, tick=0. After en rises with div=2, the first step occurs 3 cycles later.
- rst_n pulsed low while leds=70 -> leds=07 and dir=0 immediately. With LEDSCAN_SWEEP_CNT_EN defined, after 3 full bounce reversals sweeps=3, and sweeps=0 after reset.
